// File: rtl/fp_operand_entry.sv
// Operand-entry front end for the 13-bit FP adder: synchronises and debounces one
// push-button, then captures two {sign, exp, frac} operands from sw over four presses.
module fp_operand_entry #(
  parameter int DB_COUNT  = 250000,
  parameter int DB_W      = 18,
  parameter bit FORCE_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [7:0] sw,
  output logic       sign1,
  output logic [3:0] exp1,
  output logic [7:0] frac1,
  output logic       sign2,
  output logic [3:0] exp2,
  output logic [7:0] frac2,
  output logic       ops_valid,
  output logic [2:0] step,
  output logic       press
);

  typedef enum logic [2:0] {
    S_EXP1  = 3'd0,
    S_FRAC1 = 3'd1,
    S_EXP2  = 3'd2,
    S_FRAC2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_COUNT - 1);

  state_t          state;
  state_t          state_nxt;
  logic            s1;
  logic            s2;
  logic            db;
  logic            db_d;
  logic [DB_W-1:0] cnt;
  logic [7:0]      frac_cap;

  // Two-flop synchroniser, then db only follows s2 after DB_COUNT stable cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_d <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_d <= db;
      if (s2 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level only; releases never count.
  assign press    = db & ~db_d;
  assign frac_cap = {(FORCE_MSB ? 1'b1 : sw[7]), sw[6:0]};
  assign step     = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EXP1:  if (press) state_nxt = S_FRAC1;
      S_FRAC1: if (press) state_nxt = S_EXP2;
      S_EXP2:  if (press) state_nxt = S_FRAC2;
      S_FRAC2: if (press) state_nxt = S_DONE;
      S_DONE:  if (press) state_nxt = S_EXP1;
      default: state_nxt = S_EXP1;
    endcase
  end

  // ops_valid is a level with no ready: while high, all six operand fields are
  // stable and belong to one completed entry; it drops on the edge leaving S_DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_EXP1;
      ops_valid <= 1'b0;
      sign1     <= 1'b0;
      exp1      <= '0;
      frac1     <= '0;
      sign2     <= 1'b0;
      exp2      <= '0;
      frac2     <= '0;
    end else begin
      state     <= state_nxt;
      ops_valid <= (state_nxt == S_DONE);
      if (press) begin
        case (state)
          S_EXP1: begin
            sign1 <= sw[4];
            exp1  <= sw[3:0];
          end
          S_FRAC1: frac1 <= frac_cap;
          S_EXP2: begin
            sign2 <= sw[4];
            exp2  <= sw[3:0];
          end
          S_FRAC2: frac2 <= frac_cap;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_operand_entry.sv
// Directed bench for fp_operand_entry with a short debounce window; a second
// instance with FORCE_MSB=0 shares all inputs to check the raw-fraction rule.
module tb_fp_operand_entry;

  localparam int DB_COUNT = 4;
  localparam int DB_W     = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic [7:0] sw;

  logic       sign1_a, sign2_a, ops_valid_a, press_a;
  logic [3:0] exp1_a, exp2_a;
  logic [7:0] frac1_a, frac2_a;
  logic [2:0] step_a;

  logic       sign1_b, sign2_b, ops_valid_b, press_b;
  logic [3:0] exp1_b, exp2_b;
  logic [7:0] frac1_b, frac2_b;
  logic [2:0] step_b;

  int checks   = 0;
  int failures = 0;
  int pc;

  fp_operand_entry #(.DB_COUNT(DB_COUNT), .DB_W(DB_W), .FORCE_MSB(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw(sw),
    .sign1(sign1_a), .exp1(exp1_a), .frac1(frac1_a),
    .sign2(sign2_a), .exp2(exp2_a), .frac2(frac2_a),
    .ops_valid(ops_valid_a), .step(step_a), .press(press_a)
  );

  fp_operand_entry #(.DB_COUNT(DB_COUNT), .DB_W(DB_W), .FORCE_MSB(1'b0)) dut_raw (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw(sw),
    .sign1(sign1_b), .exp1(exp1_b), .frac1(frac1_b),
    .sign2(sign2_b), .exp2(exp2_b), .frac2(frac2_b),
    .ops_valid(ops_valid_b), .step(step_b), .press(press_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic v, input logic [2:0] st,
                                       input logic s1, input logic [3:0] e1, input logic [7:0] f1,
                                       input logic s2, input logic [3:0] e2, input logic [7:0] f2);
    return {2'b00, v, st, s1, e1, f1, s2, e2, f2};
  endfunction

  function automatic logic [31:0] snap_a();
    return pack(ops_valid_a, step_a, sign1_a, exp1_a, frac1_a, sign2_a, exp2_a, frac2_a);
  endfunction

  function automatic logic [31:0] snap_b();
    return pack(ops_valid_b, step_b, sign1_b, exp1_b, frac1_b, sign2_b, exp2_b, frac2_b);
  endfunction

  // driver tasks
  task automatic tick(input int n, inout int cnt);
    repeat (n) begin
      @(negedge clk);
      if (press_a) cnt++;
    end
  endtask

  task automatic press_button(input string tag, input logic [7:0] v);
    logic seen;
    @(negedge clk);
    sw      = v;
    btn_raw = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (press_a) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    sw      = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_state_a", snap_a(), 32'd0);
    check("rst_state_b", snap_b(), 32'd0);
    check("rst_press", 32'(press_a), 32'd0);

    // first press: latency from btn_raw high to capture
    reset   = 1'b0;
    btn_raw = 1'b1;
    sw      = 8'h18;
    pc      = 0;
    tick(5, pc);
    check("t1_no_early_press", 32'(pc), 32'd0);
    @(negedge clk);
    check("t1_press_edge6", 32'(press_a), 32'd1);
    check("t1_step_before", 32'(step_a), 32'd0);
    @(negedge clk);
    check("t1_press_one_cycle", 32'(press_a), 32'd0);
    check("t1_capture", snap_a(), pack(1'b0, 3'd1, 1'b1, 4'h8, 8'h00, 1'b0, 4'h0, 8'h00));
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    // remaining three presses of the entry
    press_button("p_frac1", 8'h35);
    check("frac1_force", snap_a(), pack(1'b0, 3'd2, 1'b1, 4'h8, 8'hB5, 1'b0, 4'h0, 8'h00));
    check("frac1_raw", 32'(frac1_b), 32'h35);
    press_button("p_exp2", 8'h06);
    check("exp2_capture", snap_a(), pack(1'b0, 3'd3, 1'b1, 4'h8, 8'hB5, 1'b0, 4'h6, 8'h00));
    press_button("p_frac2", 8'h80);
    check("done_a", snap_a(), pack(1'b1, 3'd4, 1'b1, 4'h8, 8'hB5, 1'b0, 4'h6, 8'h80));
    check("done_b", snap_b(), pack(1'b1, 3'd4, 1'b1, 4'h8, 8'h35, 1'b0, 4'h6, 8'h80));

    // switch activity without a press leaves everything alone
    sw = 8'hFF;
    repeat (4) @(negedge clk);
    sw = 8'h00;
    repeat (4) @(negedge clk);
    check("sw_no_effect", snap_a(), pack(1'b1, 3'd4, 1'b1, 4'h8, 8'hB5, 1'b0, 4'h6, 8'h80));

    // long hold: one press, no auto-repeat; leaving S_DONE keeps operands
    btn_raw = 1'b1;
    pc      = 0;
    tick(100, pc);
    check("hold_one_press", 32'(pc), 32'd1);
    check("hold_leave_done", snap_a(), pack(1'b0, 3'd0, 1'b1, 4'h8, 8'hB5, 1'b0, 4'h6, 8'h80));
    btn_raw = 1'b0;
    pc      = 0;
    tick(20, pc);
    check("release_no_press", 32'(pc), 32'd0);

    // bounce: toggling never passes the debounce window
    sw = 8'h12;
    pc = 0;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i % 2 == 0);
      tick(1, pc);
    end
    check("bounce_no_press", 32'(pc), 32'd0);
    btn_raw = 1'b1;
    tick(5, pc);
    check("bounce_wait_stable", 32'(pc), 32'd0);
    @(negedge clk);
    check("bounce_press", 32'(press_a), 32'd1);
    @(negedge clk);
    check("bounce_capture", snap_a(), pack(1'b0, 3'd1, 1'b1, 4'h2, 8'hB5, 1'b0, 4'h6, 8'h80));
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    // fraction MSB rule with sw=8'h12
    press_button("p_frac1_12", 8'h12);
    check("frac1_12_force", 32'(frac1_a), 32'h92);
    check("frac1_12_raw", 32'(frac1_b), 32'h12);

    // reset mid-debounce (cnt reaches 2 after the fourth edge)
    @(negedge clk);
    btn_raw = 1'b1;
    pc      = 0;
    tick(4, pc);
    check("mid_db_no_press", 32'(pc), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_db_reset_a", snap_a(), 32'd0);
    check("mid_db_reset_b", snap_b(), 32'd0);
    check("mid_db_reset_press", 32'(press_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pc    = 0;
    tick(5, pc);
    check("post_rst_no_early", 32'(pc), 32'd0);
    @(negedge clk);
    check("post_rst_press", 32'(press_a), 32'd1);
    @(negedge clk);
    check("post_rst_step", 32'(step_a), 32'd1);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    // reach S_DONE again, then reset there
    press_button("p2_frac1", 8'h44);
    press_button("p2_exp2", 8'h07);
    press_button("p2_frac2", 8'h01);
    check("done2_a", snap_a(), pack(1'b1, 3'd4, 1'b1, 4'h2, 8'hC4, 1'b0, 4'h7, 8'h81));
    check("done2_b", snap_b(), pack(1'b1, 3'd4, 1'b1, 4'h2, 8'h44, 1'b0, 4'h7, 8'h01));
    reset = 1'b1;
    @(negedge clk);
    check("done_reset_a", snap_a(), 32'd0);
    check("done_reset_b", snap_b(), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
